sobel_stream_pipe: RTL and testbench

Parametrised, backpressure-aware Sobel edge stage for raster pixel streams. It accepts one frame of IMG_W x IMG_H pixels on a valid/ready input with start-of-frame marking, builds 3x3 windows from two internal line buffers, and emits one result per interior pixel. Each result is selectable at frame start as saturated magnitude, binary threshold, |Gx| or |Gy|. It is the next-generation replacement for the fixed line-buffer + Sobel-filter pair between the pattern source and the debug/display sink.

---
 rtl/sobel_stream_pipe.sv | 191 +++++++++++++++++++
 tb/tb_sobel_stream_pipe.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_stream_pipe.sv
// sobel_stream_pipe
//   Streaming 3x3 Sobel edge stage. Pixels arrive in raster order on a
//   valid/ready port with a start-of-frame marker. Two line buffers plus a
//   3x3 window register build the neighbourhood. Every interior pixel
//   produces one result: saturated |Gx|+|Gy|, a binary threshold, |Gx| or |Gy|.
//   Pipeline: window -> Gx/Gy -> result. A single advance enable stalls
//   every stage together, so backpressure never drops or repeats a result.
// Ports
//   clk, rst          clock, synchronous active-high reset
//   s_valid/s_ready   input handshake; s_data pixel; s_sof first pixel of frame
//   cfg_mode          0=mag 1=threshold 2=|Gx| 3=|Gy|, latched on accepted s_sof
//   cfg_thresh        threshold for mode 1, latched on accepted s_sof
//   m_valid/m_ready   output handshake; m_data result; m_sof/m_eol markers
//   frame_done        pulse after the last result of a frame is accepted
//   resync_err        pulse after an s_sof accepted away from position (0,0)
module sobel_stream_pipe #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 48
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_sof,
    input  logic [1:0]        cfg_mode,
    input  logic [DATA_W+2:0] cfg_thresh,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_sof,
    output logic              m_eol,
    output logic              frame_done,
    output logic              resync_err
);
    localparam int GW     = DATA_W + 3;
    localparam int CW     = $clog2(IMG_W);
    localparam int RW     = $clog2(IMG_H);
    localparam int STAGES = 3;
    localparam logic [CW-1:0]     COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0]     ROW_LAST = RW'(IMG_H - 1);
    localparam logic [DATA_W-1:0] PIX_MAX  = '1;

    logic              adv, accept, win_ok;
    logic [CW-1:0]     col, col_cur;
    logic [RW-1:0]     row, row_cur;
    logic [1:0]        mode_q, mode_cur, mode_s1, mode_s2;
    logic [GW-1:0]     thresh_q, thresh_cur, thr_s1, thr_s2;

    logic [DATA_W-1:0] lb1 [IMG_W];   // row r-1
    logic [DATA_W-1:0] lb2 [IMG_W];   // row r-2
    logic [DATA_W-1:0] w [3][3];      // w[row][col], row 0 oldest, col 0 leftmost

    logic [STAGES:1]   vld_pipe;
    logic [2:1]        sof_pipe, eol_pipe, last_pipe;
    logic              last_q;
    logic signed [GW-1:0] gx, gy, gx_c, gy_c;
    logic [GW-1:0]     ax, ay, mag;
    logic [DATA_W-1:0] result;

    // Everything moves together: a full output register that is not being
    // taken freezes the whole pipe, including the input.
    assign adv     = !m_valid || m_ready;
    assign s_ready = adv;
    assign accept  = s_valid && adv;
    assign m_valid = vld_pipe[STAGES];

    // An accepted sof overrides the counters and the config latch for this pixel.
    assign col_cur    = s_sof ? '0 : col;
    assign row_cur    = s_sof ? '0 : row;
    assign mode_cur   = s_sof ? cfg_mode   : mode_q;
    assign thresh_cur = s_sof ? cfg_thresh : thresh_q;
    assign win_ok     = (row_cur >= RW'(2)) && (col_cur >= CW'(2));

    always_ff @(posedge clk) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            mode_q     <= '0;
            thresh_q   <= '0;
            resync_err <= 1'b0;
        end else begin
            resync_err <= accept && s_sof && ((col != '0) || (row != '0));
            if (accept) begin
                if (s_sof) begin
                    mode_q   <= cfg_mode;
                    thresh_q <= cfg_thresh;
                end
                if (col_cur == COL_LAST) begin
                    col <= '0;
                    row <= (row_cur == ROW_LAST) ? '0 : row_cur + 1'b1;
                end else begin
                    col <= col_cur + 1'b1;
                    row <= row_cur;
                end
            end
        end
    end

    // Line buffers and window hold data only; validity lives in vld_pipe.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[col_cur] <= s_data;
            lb2[col_cur] <= lb1[col_cur];
            for (int r = 0; r < 3; r++) begin
                w[r][0] <= w[r][1];
                w[r][1] <= w[r][2];
            end
            w[0][2] <= lb2[col_cur];
            w[1][2] <= lb1[col_cur];
            w[2][2] <= s_data;
        end
    end

    function automatic logic [GW-1:0] tap3(input logic [DATA_W-1:0] a,
                                           input logic [DATA_W-1:0] b,
                                           input logic [DATA_W-1:0] c);
        return GW'(a) + (GW'(b) << 1) + GW'(c);
    endfunction

    assign gx_c = signed'(tap3(w[0][2], w[1][2], w[2][2]) - tap3(w[0][0], w[1][0], w[2][0]));
    assign gy_c = signed'(tap3(w[2][0], w[2][1], w[2][2]) - tap3(w[0][0], w[0][1], w[0][2]));

    assign ax  = gx[GW-1] ? $unsigned(-gx) : $unsigned(gx);
    assign ay  = gy[GW-1] ? $unsigned(-gy) : $unsigned(gy);
    assign mag = ax + ay;   // max 8*(2^DATA_W-1), fits GW bits

    function automatic logic [DATA_W-1:0] sat(input logic [GW-1:0] v);
        return (v > GW'(PIX_MAX)) ? PIX_MAX : v[DATA_W-1:0];
    endfunction

    always_comb begin
        result = '0;
        case (mode_s2)
            2'd0:    result = sat(mag);
            2'd1:    result = (mag >= thr_s2) ? PIX_MAX : '0;
            2'd2:    result = sat(ax);
            default: result = sat(ay);
        endcase
    end

    // Config travels with each result so a new frame's sof cannot retag
    // results of the previous frame still in flight.
    always_ff @(posedge clk) begin
        if (adv) begin
            if (accept) begin
                mode_s1 <= mode_cur;
                thr_s1  <= thresh_cur;
            end
            if (vld_pipe[1]) begin
                gx      <= gx_c;
                gy      <= gy_c;
                mode_s2 <= mode_s1;
                thr_s2  <= thr_s1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe   <= '0;
            sof_pipe   <= '0;
            eol_pipe   <= '0;
            last_pipe  <= '0;
            last_q     <= 1'b0;
            m_data     <= '0;
            m_sof      <= 1'b0;
            m_eol      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= m_valid && m_ready && last_q;
            if (adv) begin
                vld_pipe[1]  <= accept && win_ok;
                sof_pipe[1]  <= (row_cur == RW'(2)) && (col_cur == CW'(2));
                eol_pipe[1]  <= col_cur == COL_LAST;
                last_pipe[1] <= (col_cur == COL_LAST) && (row_cur == ROW_LAST);
                vld_pipe[2]  <= vld_pipe[1];
                sof_pipe[2]  <= sof_pipe[1];
                eol_pipe[2]  <= eol_pipe[1];
                last_pipe[2] <= last_pipe[1];
                vld_pipe[3]  <= vld_pipe[2];
                m_sof        <= vld_pipe[2] && sof_pipe[2];
                m_eol        <= vld_pipe[2] && eol_pipe[2];
                last_q       <= vld_pipe[2] && last_pipe[2];
                if (vld_pipe[2])
                    m_data <= result;
            end
        end
    end
endmodule

// File: tb/tb_sobel_stream_pipe.sv
// Bench for sobel_stream_pipe at 8x6. Expected results come from a direct
// Sobel model of the frame image, queued as each pixel is accepted and
// popped when the DUT hands over a result.
module tb_sobel_stream_pipe;
    localparam int W = 8;
    localparam int H = 6;

    typedef struct {
        logic [7:0] d;
        logic       sof;
        logic       eol;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid, s_ready, s_sof;
    logic [7:0]  s_data;
    logic [1:0]  cfg_mode;
    logic [10:0] cfg_thresh;
    logic        m_valid, m_ready, m_sof, m_eol;
    logic [7:0]  m_data;
    logic        frame_done, resync_err;

    int   checks = 0;
    int   failures = 0;
    int   res_cnt = 0;
    int   fd_cnt = 0;
    int   rs_cnt = 0;
    int   img [H][W];
    exp_t sbq [$];

    sobel_stream_pipe #(.DATA_W(8), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sof(s_sof),
        .cfg_mode(cfg_mode), .cfg_thresh(cfg_thresh),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_sof(m_sof), .m_eol(m_eol),
        .frame_done(frame_done), .resync_err(resync_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) fd_cnt++;
        if (resync_err) rs_cnt++;
    end

    task automatic fill(input int kind, input int level);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                case (kind)
                    0:       img[y][x] = level;
                    1:       img[y][x] = (x >= 4) ? level : 0;
                    default: img[y][x] = int'($urandom_range(255));
                endcase
    endtask

    function automatic exp_t model(input int cy, input int cx, input int mode, input int thr);
        int gx, gy, ax, ay, mag, v;
        exp_t e;
        gx = (img[cy-1][cx+1] + 2*img[cy][cx+1] + img[cy+1][cx+1])
           - (img[cy-1][cx-1] + 2*img[cy][cx-1] + img[cy+1][cx-1]);
        gy = (img[cy+1][cx-1] + 2*img[cy+1][cx] + img[cy+1][cx+1])
           - (img[cy-1][cx-1] + 2*img[cy-1][cx] + img[cy-1][cx+1]);
        ax  = (gx < 0) ? -gx : gx;
        ay  = (gy < 0) ? -gy : gy;
        mag = ax + ay;
        case (mode)
            0:       v = (mag > 255) ? 255 : mag;
            1:       v = (mag >= thr) ? 255 : 0;
            2:       v = (ax > 255) ? 255 : ax;
            default: v = (ay > 255) ? 255 : ay;
        endcase
        e.d   = v[7:0];
        e.sof = (cy == 1) && (cx == 1);
        e.eol = (cx == W - 2);
        return e;
    endfunction

    // Streams the first n_px pixels of img (sof on pixel 0) and checks every
    // result the DUT delivers. With drain=0 it returns as soon as the last
    // pixel is presented, leaving later results for the next call.
    task automatic stream(input int mode, input int thr, input int v_pct,
                          input int r_pct, input int n_px, input bit drain);
        int         px = 0;
        int         budget = 0;
        bit         stalled = 0;
        logic [7:0] last_d = '0;
        exp_t       e;
        cfg_mode   = 2'(mode);
        cfg_thresh = 11'(thr);
        while ((px < n_px || (drain && sbq.size() > 0)) && budget < 20000) begin
            @(posedge clk); #1;
            s_valid = (px < n_px) && ($urandom_range(99) < v_pct);
            s_data  = 8'(img[(px / W) % H][px % W]);
            s_sof   = (px == 0);
            m_ready = ($urandom_range(99) < r_pct);
            @(negedge clk);
            if (stalled) begin
                checks++;
                if (m_data !== last_d || m_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL stall_hold m_data=%0d m_valid=%0b required m_data=%0d m_valid=1",
                             m_data, m_valid, last_d);
                end
            end
            if (m_valid && m_ready) begin
                checks++;
                if (sbq.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_result m_data=%0d required no result", m_data);
                end else begin
                    e = sbq.pop_front();
                    res_cnt++;
                    if (m_data !== e.d || m_sof !== e.sof || m_eol !== e.eol) begin
                        failures++;
                        $display("FAIL result data=%0d sof=%0b eol=%0b required data=%0d sof=%0b eol=%0b",
                                 m_data, m_sof, m_eol, e.d, e.sof, e.eol);
                    end
                end
            end
            stalled = m_valid && !m_ready;
            last_d  = m_data;
            if (s_valid && s_ready) begin
                if (px / W >= 2 && px % W >= 2)
                    sbq.push_back(model(px / W - 1, px % W - 1, mode, thr));
                px++;
            end
            budget++;
        end
        if (budget >= 20000) begin
            checks++;
            failures++;
            $display("FAIL stream_timeout pending=%0d required 0", sbq.size());
        end
        if (drain) begin
            repeat (3) begin
                @(posedge clk); #1;
                s_valid = 1'b0;
                s_sof   = 1'b0;
                m_ready = 1'b1;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; s_valid = 1'b0; s_sof = 1'b0; s_data = '0;
        m_ready = 1'b1; cfg_mode = '0; cfg_thresh = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({m_valid, m_sof, m_eol, frame_done, resync_err} !== 5'b0 || m_data !== 8'd0) begin
            failures++;
            $display("FAIL reset_outputs v/sof/eol/fd/rs=%b data=%0d required 00000 data=0",
                     {m_valid, m_sof, m_eol, frame_done, resync_err}, m_data);
        end
        checks++;
        if (s_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_s_ready got=%0b required 1", s_ready);
        end
    endtask

    task automatic test_constant;
        int r0 = res_cnt, f0 = fd_cnt, e0 = rs_cnt;
        fill(0, 77);
        stream(0, 0, 100, 100, W*H, 1);
        checks++;
        if (res_cnt - r0 != 24) begin
            failures++;
            $display("FAIL const_count got=%0d required 24", res_cnt - r0);
        end
        checks++;
        if (fd_cnt - f0 != 1 || rs_cnt - e0 != 0) begin
            failures++;
            $display("FAIL const_pulses frame_done=%0d resync=%0d required 1 0", fd_cnt - f0, rs_cnt - e0);
        end
    endtask

    task automatic test_step_modes;
        int r0 = res_cnt;
        fill(1, 40);
        stream(0, 0, 100, 100, W*H, 1);
        stream(3, 0, 100, 100, W*H, 1);
        stream(2, 0, 100, 100, W*H, 1);
        fill(1, 100);
        stream(0, 0, 100, 100, W*H, 1);
        stream(1, 300, 100, 100, W*H, 1);
        stream(1, 401, 100, 100, W*H, 1);
        checks++;
        if (res_cnt - r0 != 6*24) begin
            failures++;
            $display("FAIL step_count got=%0d required %0d", res_cnt - r0, 6*24);
        end
    endtask

    task automatic test_backpressure;
        int r0 = res_cnt, f0 = fd_cnt;
        fill(1, 40);
        stream(0, 0, 60, 50, W*H, 1);
        fill(2, 0);
        stream(1, 250, 70, 50, W*H, 1);
        stream(3, 0, 80, 40, W*H, 1);
        checks++;
        if (res_cnt - r0 != 72 || fd_cnt - f0 != 3) begin
            failures++;
            $display("FAIL backpressure_count results=%0d frame_done=%0d required 72 3",
                     res_cnt - r0, fd_cnt - f0);
        end
    endtask

    task automatic test_back_to_back;
        int r0 = res_cnt, f0 = fd_cnt, e0 = rs_cnt;
        fill(1, 100);
        stream(2, 0, 100, 100, W*H, 0);
        fill(2, 0);
        stream(0, 0, 100, 100, W*H, 0);
        stream(1, 500, 100, 100, W*H, 1);
        checks++;
        if (res_cnt - r0 != 72 || fd_cnt - f0 != 3 || rs_cnt - e0 != 0) begin
            failures++;
            $display("FAIL b2b_count results=%0d frame_done=%0d resync=%0d required 72 3 0",
                     res_cnt - r0, fd_cnt - f0, rs_cnt - e0);
        end
    endtask

    task automatic test_resync;
        int r0, f0 = fd_cnt, e0 = rs_cnt;
        fill(1, 40);
        stream(0, 0, 100, 100, 3*W + 5, 1);
        checks++;
        if (rs_cnt - e0 != 0) begin
            failures++;
            $display("FAIL resync_early got=%0d required 0", rs_cnt - e0);
        end
        r0 = res_cnt;
        fill(2, 0);
        stream(0, 0, 100, 100, W*H, 1);
        checks++;
        if (rs_cnt - e0 != 1) begin
            failures++;
            $display("FAIL resync_pulse got=%0d required 1", rs_cnt - e0);
        end
        checks++;
        if (res_cnt - r0 != 24 || fd_cnt - f0 != 1) begin
            failures++;
            $display("FAIL resync_frame results=%0d frame_done=%0d required 24 1",
                     res_cnt - r0, fd_cnt - f0);
        end
    endtask

    task automatic test_mid_reset;
        int r0, f0;
        fill(1, 40);
        stream(0, 0, 100, 100, 30, 0);
        @(posedge clk); #1;
        s_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sbq.delete();
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset m_valid=%0b s_ready=%0b required 0 1", m_valid, s_ready);
        end
        r0 = res_cnt;
        f0 = fd_cnt;
        fill(2, 0);
        stream(0, 0, 100, 100, W*H, 1);
        checks++;
        if (res_cnt - r0 != 24 || fd_cnt - f0 != 1) begin
            failures++;
            $display("FAIL mid_reset_frame results=%0d frame_done=%0d required 24 1",
                     res_cnt - r0, fd_cnt - f0);
        end
    endtask

    initial begin
        test_reset();
        test_constant();
        test_step_modes();
        test_backpressure();
        test_back_to_back();
        test_resync();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
